// File: rtl/sync_req_ack_ctrl.sv
// rtl/sync_req_ack_ctrl.sv - source-side 4-phase req/ack word transfer controller
// Holds one accepted word on dataOut while reqOut/ackIn complete a full 4-phase handshake.
module sync_req_ack_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256,
  parameter int TO_WIDTH   = 9,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  syncClk,
  input  logic                  syncRst,
  input  logic                  srcValid,
  output logic                  srcReady,
  input  logic [DATA_WIDTH-1:0] srcData,
  output logic                  reqOut,
  output logic [DATA_WIDTH-1:0] dataOut,
  input  logic                  ackIn,
  output logic                  busy,
  output logic                  timeoutErr,
  input  logic                  clearErr,
  output logic [CNT_WIDTH-1:0]  xferCount
);

  typedef enum logic [1:0] {IDLE, REQ, REL, ERR} state_t;

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);
  localparam logic [TO_WIDTH-1:0] TO_MAX  = '1;

  state_t                state_q, state_d;
  logic                  req_q, req_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [TO_WIDTH-1:0]   to_q, to_d;
  logic                  to_hit;

  assign to_hit     = (TIMEOUT != 0) && (to_q == TO_LAST);
  assign srcReady   = (state_q == IDLE) && !ackIn;
  assign busy       = (state_q != IDLE);
  assign reqOut     = req_q;
  assign dataOut    = data_q;
  assign timeoutErr = err_q;
  assign xferCount  = cnt_q;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (srcValid && srcReady) begin
          data_d  = srcData;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ackIn) begin
          req_d   = 1'b0;
          state_d = REL;
        end else if (to_hit) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      REL: begin
        if (!ackIn) begin
          cnt_d   = cnt_q + CNT_WIDTH'(1);
          state_d = IDLE;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      ERR: begin
        // A still-high ack would look like a fresh handshake, so clearing waits for it to drop.
        if (clearErr && !ackIn) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) begin
      to_d = '0;
    end else if (((state_q == REQ) || (state_q == REL)) && (to_q != TO_MAX)) begin
      to_d = to_q + TO_WIDTH'(1);
    end else begin
      to_d = to_q;
    end
  end

  always_ff @(posedge syncClk or posedge syncRst) begin
    if (syncRst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

endmodule

// File: tb/tb_sync_req_ack_ctrl.sv
// tb/tb_sync_req_ack_ctrl.sv - directed self-checking bench for sync_req_ack_ctrl
module tb_sync_req_ack_ctrl;

  logic        syncClk = 1'b0;
  logic        syncRst;
  logic        srcValid;
  logic        srcReady;
  logic [31:0] srcData;
  logic        reqOut;
  logic [31:0] dataOut;
  logic        ackIn;
  logic        busy;
  logic        timeoutErr;
  logic        clearErr;
  logic [3:0]  xferCount;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_cnt;

  sync_req_ack_ctrl #(
    .DATA_WIDTH(32), .TIMEOUT(8), .TO_WIDTH(4), .CNT_WIDTH(4)
  ) dut (
    .syncClk(syncClk), .syncRst(syncRst), .srcValid(srcValid), .srcReady(srcReady),
    .srcData(srcData), .reqOut(reqOut), .dataOut(dataOut), .ackIn(ackIn), .busy(busy),
    .timeoutErr(timeoutErr), .clearErr(clearErr), .xferCount(xferCount)
  );

  initial begin
    forever #5 syncClk = ~syncClk;
  end

  task automatic tick();
    @(posedge syncClk);
    #1;
  endtask

  task automatic test_reset();
    syncRst = 1'b1; srcValid = 1'b0; srcData = 32'h0; ackIn = 1'b0; clearErr = 1'b0;
    tick(); tick();
    checks++; if (srcReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", srcReady); end
    checks++; if (reqOut !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", reqOut); end
    checks++; if (dataOut !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", dataOut); end
    checks++; if (xferCount !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", xferCount); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (timeoutErr !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", timeoutErr); end
    syncRst = 1'b0;
    exp_cnt = 4'd0;
    tick();
  endtask

  task automatic test_single();
    srcValid = 1'b1; srcData = 32'hA5A5_0001;
    tick();
    srcValid = 1'b0; srcData = 32'h1234_5678;
    checks++; if (reqOut !== 1'b1) begin errors++; $display("FAIL single_req_rise got %0b exp 1", reqOut); end
    checks++; if (srcReady !== 1'b0) begin errors++; $display("FAIL single_ready_busy got %0b exp 0", srcReady); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (reqOut !== 1'b1 || dataOut !== 32'hA5A5_0001) begin
        errors++; $display("FAIL single_req_hold got req=%0b data=%h exp req=1 data=a5a50001", reqOut, dataOut);
      end
    end
    ackIn = 1'b1;
    tick();
    checks++; if (reqOut !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL single_rel got req=%0b busy=%0b exp req=0 busy=1", reqOut, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (reqOut !== 1'b0 || busy !== 1'b1 || dataOut !== 32'hA5A5_0001) begin
        errors++; $display("FAIL single_rel_hold got req=%0b busy=%0b data=%h", reqOut, busy, dataOut);
      end
    end
    ackIn = 1'b0;
    tick();
    exp_cnt = exp_cnt + 4'd1;
    checks++; if (xferCount !== exp_cnt) begin errors++; $display("FAIL single_cnt got %0d exp %0d", xferCount, exp_cnt); end
    checks++; if (srcReady !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL single_done got ready=%0b busy=%0b exp ready=1 busy=0", srcReady, busy);
    end
    checks++; if (dataOut !== 32'hA5A5_0001) begin errors++; $display("FAIL single_data_final got %h exp a5a50001", dataOut); end
  endtask

  task automatic test_back_to_back();
    int   acc;
    int   cyc;
    logic req_prev;
    logic took;
    acc = 0; cyc = 0; req_prev = 1'b0;
    srcValid = 1'b1; srcData = 32'hB0B0_0000;
    while (acc < 5 && cyc < 60) begin
      took = srcValid && srcReady;
      req_prev = reqOut;
      tick();
      cyc++;
      ackIn = req_prev;
      if (took) begin
        checks++; if (dataOut !== (32'hB0B0_0000 + acc) || reqOut !== 1'b1) begin
          errors++; $display("FAIL b2b_word%0d got data=%h req=%0b exp data=%h req=1", acc, dataOut, reqOut, 32'hB0B0_0000 + acc);
        end
        acc++;
        srcData = 32'hB0B0_0000 + acc;
        if (acc == 5) srcValid = 1'b0;
      end
    end
    while ((busy || ackIn) && cyc < 80) begin
      req_prev = reqOut;
      tick();
      cyc++;
      ackIn = req_prev;
    end
    exp_cnt = exp_cnt + 4'd5;
    checks++; if (acc != 5) begin errors++; $display("FAIL b2b_accepts got %0d exp 5", acc); end
    checks++; if (xferCount !== exp_cnt) begin errors++; $display("FAIL b2b_cnt got %0d exp %0d", xferCount, exp_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy=%0b exp 0", busy); end
  endtask

  task automatic test_timeout();
    int high;
    high = 0;
    ackIn = 1'b0;
    srcValid = 1'b1; srcData = 32'hDEAD_0008;
    tick();
    srcValid = 1'b0;
    while (reqOut === 1'b1 && high < 20) begin
      high++;
      tick();
    end
    checks++; if (high != 8) begin errors++; $display("FAIL timeout_len got %0d exp 8", high); end
    checks++; if (timeoutErr !== 1'b1 || reqOut !== 1'b0) begin
      errors++; $display("FAIL timeout_err got err=%0b req=%0b exp err=1 req=0", timeoutErr, reqOut);
    end
    srcValid = 1'b1;
    #1;
    checks++; if (srcReady !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL timeout_ready got ready=%0b busy=%0b exp ready=0 busy=1", srcReady, busy);
    end
    srcValid = 1'b0;
    clearErr = 1'b1; ackIn = 1'b1;
    tick();
    checks++; if (timeoutErr !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL err_stale_clear got err=%0b busy=%0b exp err=1 busy=1", timeoutErr, busy);
    end
    ackIn = 1'b0;
    tick();
    clearErr = 1'b0;
    checks++; if (timeoutErr !== 1'b0 || busy !== 1'b0 || srcReady !== 1'b1) begin
      errors++; $display("FAIL timeout_clear got err=%0b busy=%0b ready=%0b exp 0 0 1", timeoutErr, busy, srcReady);
    end
    checks++; if (xferCount !== exp_cnt) begin errors++; $display("FAIL timeout_cnt got %0d exp %0d", xferCount, exp_cnt); end
  endtask

  task automatic test_stale_ack();
    ackIn = 1'b1; srcValid = 1'b1; srcData = 32'hCAFE_0000;
    #1;
    checks++; if (srcReady !== 1'b0) begin errors++; $display("FAIL stale_ready got %0b exp 0", srcReady); end
    tick();
    checks++; if (busy !== 1'b0 || reqOut !== 1'b0 || dataOut !== 32'hDEAD_0008) begin
      errors++; $display("FAIL stale_noaccept got busy=%0b req=%0b data=%h", busy, reqOut, dataOut);
    end
    ackIn = 1'b0; srcValid = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    syncRst = 1'b1;
    tick();
    syncRst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      srcValid = 1'b1; srcData = 32'h7000_0000 + i;
      tick();
      srcValid = 1'b0; ackIn = 1'b1;
      tick();
      ackIn = 1'b0;
      tick();
      if (i == 15) begin
        checks++; if (xferCount !== 4'd0) begin errors++; $display("FAIL wrap16_cnt got %0d exp 0", xferCount); end
      end
    end
    checks++; if (xferCount !== 4'd1) begin errors++; $display("FAIL wrap17_cnt got %0d exp 1", xferCount); end
    checks++; if (dataOut !== 32'h7000_0010) begin errors++; $display("FAIL wrap_data got %h exp 70000010", dataOut); end
  endtask

  task automatic test_reset_mid();
    srcValid = 1'b1; srcData = 32'h5555_AAAA;
    tick();
    srcValid = 1'b0;
    checks++; if (reqOut !== 1'b1) begin errors++; $display("FAIL mid_req got %0b exp 1", reqOut); end
    #2 syncRst = 1'b1;
    #1;
    checks++; if (reqOut !== 1'b0 || busy !== 1'b0 || xferCount !== 4'd0) begin
      errors++; $display("FAIL mid_async got req=%0b busy=%0b cnt=%0d exp 0 0 0", reqOut, busy, xferCount);
    end
    tick();
    syncRst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || srcReady !== 1'b1 || reqOut !== 1'b0) begin
      errors++; $display("FAIL mid_release got busy=%0b ready=%0b req=%0b exp 0 1 0", busy, srcReady, reqOut);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_stale_ack();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
